// File: rtl/mem_responder.sv
// Single-outstanding line-granular memory responder serving an instruction and a data cache port.
// Define MEM_RR_ARB_EN for round-robin arbitration between the ports; default is fixed data priority.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

// state | meaning
// IDLE  | ready to accept one request from the granted port
// BUSY  | request latched, latency counter running down
// RESP  | one-cycle response; write commits / read data driven
module mem_responder #(
  parameter int LATENCY     = 5,
  parameter int LINE_BITS   = 128,
  parameter int DEPTH_LINES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iReqValid,
  input  logic [`WORD_SIZE-1:0]  iReqAddr,
  output logic                   iReady,
  output logic                   iRespValid,
  output logic [LINE_BITS-1:0]   iRespData,
  input  logic                   dReqValid,
  input  logic                   dReqWrite,
  input  logic [`WORD_SIZE-1:0]  dReqAddr,
  input  logic [LINE_BITS-1:0]   dReqWData,
  output logic                   dReady,
  output logic                   dRespValid,
  output logic [LINE_BITS-1:0]   dRespData
);

  localparam int IDX_W = $clog2(DEPTH_LINES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 port_q, port_d;       // 1 = data port owns the request
  logic                 write_q, write_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;

  logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

  logic                 grant_data;
  logic                 prio_data;
  logic                 accept_i;
  logic                 accept_d;
  logic                 accept;
  logic                 resp_active;
  logic                 mem_we;
  logic [LINE_BITS-1:0] rd_line;

  logic                 unused_addr_bits;
  assign unused_addr_bits = ^{iReqAddr[`WORD_SIZE-1:IDX_W+4], iReqAddr[3:0],
                              dReqAddr[`WORD_SIZE-1:IDX_W+4], dReqAddr[3:0]};

  // Arbitration: only a true collision consults the priority bit.
  always_comb begin
    grant_data = 1'b1;
    if (iReqValid && !dReqValid) begin
      grant_data = 1'b0;
    end else if (iReqValid && dReqValid) begin
      grant_data = prio_data;
    end
  end

`ifdef MEM_RR_ARB_EN
  // Priority flips after each contested grant so the loser wins the next collision.
  logic prio_data_q, prio_data_d;

  always_comb begin
    prio_data_d = prio_data_q;
    if (iReqValid && dReqValid && accept) begin
      prio_data_d = !grant_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_data_q <= 1'b1;
    end else begin
      prio_data_q <= prio_data_d;
    end
  end

  assign prio_data = prio_data_q;
`else
  assign prio_data = 1'b1;
`endif

  assign dReady   = (state_q == IDLE) && !rst && grant_data;
  assign iReady   = (state_q == IDLE) && !rst && !grant_data;
  assign accept_d = dReqValid && dReady;
  assign accept_i = iReqValid && iReady;
  assign accept   = accept_d || accept_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    port_d  = port_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY - 1);
          port_d  = accept_d;
          write_d = accept_d && dReqWrite;
          idx_d   = accept_d ? dReqAddr[IDX_W+3:4] : iReqAddr[IDX_W+3:4];
          wdata_d = accept_d ? dReqWData : '0;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: cnt_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      port_q  <= 1'b1;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Backing store is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    resp_active = (state_q == RESP) && !rst;
    mem_we      = resp_active && write_q;
    rd_line     = mem_q[idx_q];
    iRespValid  = resp_active && !port_q;
    dRespValid  = resp_active && port_q;
    iRespData   = iRespValid ? rd_line : '0;
    dRespData   = (dRespValid && !write_q) ? rd_line : '0;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboard of expected responses plus
// directed scenarios for reset, ordering, arbitration, aliasing and LATENCY=1.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_mem_responder;

  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iReqValid = 1'b0;
  logic [31:0]  iReqAddr = '0;
  logic         iReady, iRespValid;
  logic [127:0] iRespData;
  logic         dReqValid = 1'b0, dReqWrite = 1'b0;
  logic [31:0]  dReqAddr = '0;
  logic [127:0] dReqWData = '0;
  logic         dReady, dRespValid;
  logic [127:0] dRespData;

  logic         d1ReqValid = 1'b0, d1ReqWrite = 1'b0;
  logic [31:0]  d1ReqAddr = '0;
  logic [127:0] d1ReqWData = '0;
  logic         d1Ready, d1RespValid;
  logic [127:0] d1RespData;
  logic         i1Ready, i1RespValid;
  logic [127:0] i1RespData;
  logic         i1ReqValid = 1'b0;
  logic [31:0]  i1ReqAddr = '0;

  mem_responder #(.LATENCY(LAT), .LINE_BITS(128), .DEPTH_LINES(1024)) dut (
    .clk(clk), .rst(rst),
    .iReqValid(iReqValid), .iReqAddr(iReqAddr), .iReady(iReady),
    .iRespValid(iRespValid), .iRespData(iRespData),
    .dReqValid(dReqValid), .dReqWrite(dReqWrite), .dReqAddr(dReqAddr),
    .dReqWData(dReqWData), .dReady(dReady),
    .dRespValid(dRespValid), .dRespData(dRespData)
  );

  mem_responder #(.LATENCY(1), .LINE_BITS(128), .DEPTH_LINES(16)) dut1 (
    .clk(clk), .rst(rst),
    .iReqValid(i1ReqValid), .iReqAddr(i1ReqAddr), .iReady(i1Ready),
    .iRespValid(i1RespValid), .iRespData(i1RespData),
    .dReqValid(d1ReqValid), .dReqWrite(d1ReqWrite), .dReqAddr(d1ReqAddr),
    .dReqWData(d1ReqWData), .dReady(d1Ready),
    .dRespValid(d1RespValid), .dRespData(d1RespData)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int resp_count = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    bit           is_d;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model [int];
  exp_t         e;
  logic [127:0] got;

  function automatic int line_idx(input logic [31:0] addr);
    return int'((addr >> 4) & 32'd1023);
  endfunction

  function automatic logic [127:0] mread(input int idx);
    if (model.exists(idx)) return model[idx];
    return '0;
  endfunction

  // Response monitor: every response pops the scoreboard; idle data must be zero.
  always @(negedge clk) begin
    checks++;
    if ((!iRespValid && iRespData !== '0) || (!dRespValid && dRespData !== '0)) begin
      failures++;
      $display("FAIL idle_zero cyc=%0d got i=%h d=%h required 0", cyc, iRespData, dRespData);
    end
    if (iRespValid || dRespValid) begin
      resp_count++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp cyc=%0d iv=%b dv=%b required none", cyc, iRespValid, dRespValid);
      end else begin
        e = sb.pop_front();
        got = dRespValid ? dRespData : iRespData;
        if ((iRespValid && dRespValid) || (e.is_d != dRespValid) || (got !== e.data) || (cyc != e.cyc)) begin
          failures++;
          $display("FAIL resp cyc=%0d port_d=%b data=%h required cyc=%0d port_d=%b data=%h",
                   cyc, dRespValid, got, e.cyc, e.is_d, e.data);
        end
      end
    end
  end

  task automatic send(input bit is_d, input bit wr, input logic [31:0] addr,
                      input logic [127:0] wd, output int acc);
    int n = 0;
    acc = -1;
    if (is_d) begin
      dReqValid = 1'b1; dReqWrite = wr; dReqAddr = addr; dReqWData = wd;
    end else begin
      iReqValid = 1'b1; iReqAddr = addr;
    end
    while (acc < 0 && n < 200) begin
      @(negedge clk);
      if (is_d ? dReady : iReady) acc = cyc;
      n++;
    end
    if (acc < 0) begin
      checks++; failures++;
      $display("FAIL accept_timeout port_d=%b addr=%h", is_d, addr);
    end else if (wr) begin
      sb.push_back('{1'b1, 128'd0, acc + LAT});
      model[line_idx(addr)] = wd;
    end else begin
      sb.push_back('{is_d, mread(line_idx(addr)), acc + LAT});
    end
    @(posedge clk); #1;
    if (is_d) dReqValid = 1'b0; else iReqValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({iReady, dReady, iRespValid, dRespValid} !== 4'b0000 || iRespData !== '0 || dRespData !== '0) begin
      failures++;
      $display("FAIL reset_hold rdy/valid=%b required 0000", {iReady, dReady, iRespValid, dRespValid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({iReady, dReady} !== 2'b01) begin
      failures++;
      $display("FAIL reset_release i/dReady=%b required 01", {iReady, dReady});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int a0, a1;
    send(1'b1, 1'b1, 32'h100, 128'hDEADBEEF_CAFEF00D_12345678_00000001, a0);
    send(1'b1, 1'b0, 32'h100, '0, a1);
    drain();
    checks++;
    if (a1 - a0 != LAT + 1) begin
      failures++;
      $display("FAIL wr_rd_spacing got=%0d required %0d", a1 - a0, LAT + 1);
    end
  endtask

  task automatic test_single_fetch();
    int a, dummy;
    send(1'b1, 1'b1, 32'h40, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, dummy);
    drain();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    iReqValid = 1'b1; iReqAddr = 32'h40;
    @(negedge clk);
    checks++;
    if (iReady !== 1'b1) begin
      failures++;
      $display("FAIL fetch_ready0 iReady=%b required 1", iReady);
    end
    a = cyc;
    sb.push_back('{1'b0, mread(4), a + LAT});
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      checks++;
      if (iReady !== 1'b0) begin
        failures++;
        $display("FAIL fetch_busy_ready cycle=%0d iReady=%b required 0", k, iReady);
      end
    end
    @(posedge clk); #1;
    iReqValid = 1'b0;
    drain();
  endtask

  task automatic collide(output int acc_d, output int acc_i);
    int ad, ai;
    fork
      send(1'b1, 1'b0, 32'h300, '0, ad);
      send(1'b0, 1'b0, 32'h200, '0, ai);
    join
    acc_d = ad; acc_i = ai;
    drain();
  endtask

  task automatic test_collision();
    int ad, ai, dummy;
    send(1'b1, 1'b1, 32'h200, {4{32'hA5A5_0200}}, dummy);
    send(1'b1, 1'b1, 32'h300, {4{32'h5A5A_0300}}, dummy);
    drain();
    collide(ad, ai);
    checks++;
    if (ai - ad != LAT + 1) begin
      failures++;
      $display("FAIL collide1 instr_minus_data=%0d required %0d", ai - ad, LAT + 1);
    end
    collide(ad, ai);
    checks++;
`ifdef MEM_RR_ARB_EN
    if (ad - ai != LAT + 1) begin
      failures++;
      $display("FAIL collide2_rr data_minus_instr=%0d required %0d", ad - ai, LAT + 1);
    end
`else
    if (ai - ad != LAT + 1) begin
      failures++;
      $display("FAIL collide2_fixed instr_minus_data=%0d required %0d", ai - ad, LAT + 1);
    end
`endif
  endtask

  task automatic test_reset_abort();
    int a, rc, dummy;
    send(1'b1, 1'b1, 32'h500, {4{32'h1111_2222}}, dummy);
    drain();
    dReqValid = 1'b1; dReqWrite = 1'b1; dReqAddr = 32'h500; dReqWData = {4{32'hBAD0_BAD0}};
    @(negedge clk);
    checks++;
    if (dReady !== 1'b1) begin
      failures++;
      $display("FAIL abort_accept dReady=%b required 1", dReady);
    end
    a = cyc;
    @(posedge clk); #1;
    dReqValid = 1'b0; dReqWrite = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rc = resp_count;
    repeat (LAT + 3) @(negedge clk);
    checks++;
    if (resp_count != rc) begin
      failures++;
      $display("FAIL abort_no_resp responses=%0d required 0 (accepted cyc %0d)", resp_count - rc, a);
    end
    @(posedge clk); #1;
    send(1'b1, 1'b0, 32'h500, '0, dummy);
    drain();
  endtask

  task automatic test_alias();
    int dummy;
    send(1'b1, 1'b1, 32'h10, 128'hFEED_0001_FEED_0002_FEED_0003_FEED_0004, dummy);
    send(1'b1, 1'b0, 32'h4010, '0, dummy);
    send(1'b0, 1'b0, 32'h1C, '0, dummy);
    send(1'b1, 1'b1, 32'h401C, 128'h7777_0000_8888_0000_9999_0000_AAAA_0001, dummy);
    send(1'b0, 1'b0, 32'h10, '0, dummy);
    drain();
  endtask

  task automatic test_random();
    int dummy;
    logic [31:0] addr;
    for (int k = 0; k < 8; k++) begin
      send(1'b1, 1'b1, 32'h800 + 32'(k * 16), {$urandom, $urandom, $urandom, $urandom}, dummy);
    end
    for (int k = 0; k < 16; k++) begin
      addr = 32'h800 + 32'($urandom_range(0, 7) * 16) + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0)
        send(1'b1, 1'b1, addr, {$urandom, $urandom, $urandom, $urandom}, dummy);
      else
        send(1'($urandom_range(0, 1)), 1'b0, addr, '0, dummy);
    end
    drain();
  endtask

  task automatic test_latency1();
    logic [127:0] w = 128'h1357_9BDF_2468_ACE0_0F0F_F0F0_55AA_AA55;
    d1ReqValid = 1'b1; d1ReqWrite = 1'b1; d1ReqAddr = 32'h30; d1ReqWData = w;
    @(negedge clk);
    checks++;
    if (d1Ready !== 1'b1) begin
      failures++;
      $display("FAIL lat1_accept0 dReady=%b required 1", d1Ready);
    end
    @(posedge clk); #1;
    d1ReqWrite = 1'b0;
    @(negedge clk);
    checks++;
    if ({d1RespValid, d1Ready} !== 2'b10 || d1RespData !== '0) begin
      failures++;
      $display("FAIL lat1_wr_ack valid/ready=%b data=%h required 10 data 0", {d1RespValid, d1Ready}, d1RespData);
    end
    @(negedge clk);
    checks++;
    if ({d1RespValid, d1Ready} !== 2'b01) begin
      failures++;
      $display("FAIL lat1_b2b valid/ready=%b required 01", {d1RespValid, d1Ready});
    end
    @(posedge clk); #1;
    d1ReqValid = 1'b0;
    @(negedge clk);
    checks++;
    if (d1RespValid !== 1'b1 || d1RespData !== w) begin
      failures++;
      $display("FAIL lat1_rd valid=%b data=%h required 1 data=%h", d1RespValid, d1RespData, w);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_single_fetch();
    test_collision();
    test_reset_abort();
    test_alias();
    test_random();
    test_latency1();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 5, cycles from request acceptance to response (legal 1..15).
REQ-002 Parameter LINE_BITS, default 128, cache line width (4 x `WORD_SIZE).
REQ-003 Parameter DEPTH_LINES, default 1024, power of two, lines of backing storage.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 iReqValid  input  1  instruction cache line-fill request.
REQ-007 iReqAddr  input  `WORD_SIZE  instruction cache byte address.
REQ-008 iReady  output  1  instruction port may be accepted this cycle.
REQ-009 iRespValid  output  1  one-cycle instruction fill pulse.
REQ-010 iRespData  output  LINE_BITS  instruction fill line.
REQ-011 dReqValid  input  1  data cache request.
REQ-012 dReqWrite  input  1  1 = line writeback, 0 = line fill.
REQ-013 dReqAddr  input  `WORD_SIZE  data cache byte address.
REQ-014 dReqWData  input  LINE_BITS  writeback line.
REQ-015 dReady  output  1  data port may be accepted this cycle.
REQ-016 dRespValid  output  1  one-cycle data completion pulse (fill or write ack).
REQ-017 dRespData  output  LINE_BITS  data fill line; 0 on write ack.

Function
REQ-018 FSM states IDLE, BUSY, RESP; one outstanding request total.
REQ-019 iReady/dReady SHALL equal (state==IDLE) && !rst && grant-to-that-port; acceptance = Valid && Ready same cycle.
REQ-020 IDLE: both valid -> data port granted, instruction port sees Ready=0 and must hold its request.
REQ-021 On acceptance: latch port id, write flag, line index, write data; load counter with LATENCY-1; go BUSY (LATENCY==1 -> RESP directly).
REQ-022 BUSY: decrement counter each cycle; at 0 go RESP; requests arriving in BUSY/RESP are not accepted.
REQ-023 RESP: exactly one cycle; assert granted port's RespValid; writes commit to storage this cycle; reads return storage contents this cycle; next state IDLE.
REQ-024 Total latency: acceptance in cycle N -> RespValid in cycle N+LATENCY; next acceptance no earlier than N+LATENCY+1.
REQ-025 Line index = addr[log2(DEPTH_LINES)+3:4]; addr[3:0] ignored; higher bits ignored (wrap-around modulo DEPTH_LINES).
REQ-026 RespData SHALL be 0 whenever corresponding RespValid is 0.
REQ-027 Read after write to same line returns written data (write committed before any later acceptance).
REQ-028 Word 0 of a line = bits [`WORD_SIZE-1:0] (little-endian word order).

Reset
REQ-029 rst high for one edge: state IDLE, counter 0, all RespValid 0, all RespData 0, grant to data port.
REQ-030 Reset mid-operation aborts the in-flight request: no response, no storage write.
REQ-031 Storage contents are not cleared by rst.

Configuration
REQ-032 Macro MEM_RR_ARB_EN defined: round-robin arbitration -- on simultaneous requests, the port not granted last wins; after reset data port has priority.
REQ-033 MEM_RR_ARB_EN undefined: fixed priority, data port always wins per REQ-020.

Verification
REQ-034 Reset, iReqValid=1 addr 0x40 cycle 0 -> iReady=1 cycle 0, iRespValid pulse cycle 5 with line index 4 contents, iReady=0 cycles 1..5.
REQ-035 dReqWrite addr 0x100 data 0xDEADBEEF_..._00000001, then dRead 0x100 -> dRespValid cycles 5 and 11, second dRespData equals written line.
REQ-036 iReqValid and dReqValid together in IDLE -> data served first (dRespValid cycle 5), instruction accepted cycle 6, iRespValid cycle 11; with MEM_RR_ARB_EN a second collision grants instruction first.
REQ-037 Write accepted at cycle 0, rst at cycle 3 -> no dRespValid, subsequent read of that line returns prior contents.
REQ-038 Address 0x4010 with DEPTH_LINES=1024 -> aliases line 1 (same data as 0x10); addr 0x1C returns same line as 0x10.
REQ-039 LATENCY=1 -> acceptance cycle 0, RespValid cycle 1, back-to-back acceptance cycle 2.
